mem_load_store_unit: RTL
========================

MEM_LOAD_STORE_UNIT -- requirements
Module: mem_load_store_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64, meaning the maximum number of ACCESS cycles to wait for i_mem_ack.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_valid, input, 1 bit: a memory-stage instruction is present.
REQ-005 SHALL have port i_opcode, input, 6 bits: MIPS opcode (lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, lwu 100111, sb 101000, sh 101001, sw 101011).
REQ-006 SHALL have port i_addr, input, 32 bits: effective byte address.
REQ-007 SHALL have port i_wdata, input, 32 bits: store data (rt).
REQ-008 SHALL have port o_stall, output, 1 bit: freeze the upstream pipeline.
REQ-009 SHALL have the following data-memory ports:
- o_mem_req, output, 1 bit: request.
- o_mem_we, output, 1 bit: write enable.
- o_mem_be, output, 4 bits: byte enables.
- o_mem_addr, output, 32 bits: word-aligned address, bits [1:0] = 00.
- o_mem_wdata, output, 32 bits: lane-steered write data.
REQ-010 SHALL have port i_mem_ack, input, 1 bit: memory completes the held request.
REQ-011 SHALL have port i_mem_rdata, input, 32 bits: read word, valid with i_mem_ack.
REQ-012 SHALL have port o_wb_valid, output, 1 bit: one-cycle pulse, load result ready for writeback.
REQ-013 SHALL have port o_wb_opcode, output, 6 bits: opcode of the completed load, consumed by the writeback sign/zero extender.
REQ-014 SHALL have port o_wb_rdata, output, 32 bits: load data right-aligned and not extended.
REQ-015 SHALL have ports o_misalign and o_bus_err, output, 1 bit each: one-cycle exception pulses.

Function
REQ-016 SHALL implement the FSM states IDLE and ACCESS; the byte at address offset k SHALL map to lane [8k+7:8k] (little-endian).
REQ-017 In IDLE, when i_valid is high with an aligned load/store opcode, the unit SHALL accept it:
- o_stall is high that cycle.
- address, opcode and steered data/be are registered.
- the FSM enters ACCESS with o_mem_req high on the next cycle.
REQ-018 Store steering SHALL be:
- sb: wdata = i_wdata[7:0] replicated 4 times, be = 0001 shifted left by addr[1:0].
- sh: wdata = i_wdata[15:0] replicated 2 times, be = 0011 if addr[1] is 0, otherwise 1100.
- sw: wdata = i_wdata, be = 1111.
REQ-019 Loads SHALL drive o_mem_we = 0 and be = 1111.
REQ-020 In ACCESS, o_mem_req/we/be/addr/wdata SHALL stay stable until i_mem_ack, and o_stall SHALL equal NOT i_mem_ack.
REQ-021 On i_mem_ack for a load, the unit SHALL register o_wb_rdata:
- lb/lbu: i_mem_rdata >> 8*addr[1:0].
- lh/lhu: i_mem_rdata >> 16*addr[1].
- lw/lwu: unshifted.
- upper bits: whatever the shift produces.
REQ-022 On that load ack, the unit SHALL also pulse o_wb_valid for the next cycle and hold o_wb_opcode.
REQ-023 On i_mem_ack for a store, the unit SHALL return to IDLE with no o_wb_valid.
REQ-024 Minimum load latency SHALL be: accept at cycle N, o_mem_req at N+1, ack at N+1 at the earliest, o_wb_valid at N+2.
REQ-025 A misaligned request SHALL issue no memory request and no stall, pulse o_misalign at N+1, and leave the FSM in IDLE. Misaligned means:
- lh/lhu/sh with addr[0] = 1.
- lw/lwu/sw with addr[1:0] != 00.
REQ-026 A non-memory opcode, or i_valid low, SHALL be ignored with o_stall low.
REQ-027 A cycle counter SHALL run in ACCESS; at MEM_TIMEOUT cycles without ack the unit SHALL:
- drop o_mem_req.
- pulse o_bus_err for one cycle.
- deassert o_stall.
- return to IDLE without o_wb_valid.
REQ-028 i_mem_ack while in IDLE SHALL be ignored.
REQ-029 An ack arriving in the timeout cycle SHALL win over the timeout: normal completion, no o_bus_err.
REQ-030 A new request SHALL be accepted in the cycle immediately after completion, giving back-to-back throughput of one access per ack.

Reset
REQ-031 While reset is high, all outputs SHALL be 0, the FSM SHALL be IDLE and the counter 0, independent of clk.
REQ-032 Reset during ACCESS SHALL drop o_mem_req immediately and discard the access; the unit SHALL NOT pulse o_wb_valid, o_misalign or o_bus_err.

Structure
REQ-033 A shared package SHALL hold the opcode constants, FSM state encoding, byte-enable constants and the MEM_TIMEOUT default.
REQ-034 Store/load lane steering SHALL be a combinational sub-module mem_lane_align; the FSM, counter and registers stay in the top.

Verification
REQ-035 sb with addr=0x1002, wdata=0x000000A5 and ack 1 cycle after req -> o_mem_addr=0x1000, be=0100, wdata=0xA5A5A5A5, we=1; no o_wb_valid.
REQ-036 lb with addr=0x2003, memory word 0x80112233 and ack after 3 cycles -> o_stall high 4 cycles (accept cycle plus 3 ACCESS cycles without ack); o_wb_rdata=0x00000080, o_wb_opcode=100000, o_wb_valid one pulse.
REQ-037 lh with addr=0x3001 -> o_misalign pulse at N+1; o_mem_req never high; o_stall low.
REQ-038 lw with MEM_TIMEOUT=4 and no ack -> o_mem_req high 4 cycles, then o_bus_err pulse, IDLE; a late ack produces no o_wb_valid.
REQ-039 Reset asserted while o_mem_req is high -> o_mem_req=0 in the same cycle; no pulses after release.
REQ-040 Back-to-back sw then lhu (addr=0x4002, word 0xBEEF1234) -> the second req starts the cycle after the first ack; o_wb_rdata=0x0000BEEF.

Source files
------------

// File: rtl/mem_load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_load_store_unit_pkg
// Shared definitions for the data-memory load/store unit:
//   - MIPS load/store opcode constants
//   - FSM state encoding (IDLE / ACCESS)
//   - byte-enable constants
//   - default access timeout
//   - opcode decode helper functions
// -----------------------------------------------------------------------------
package mem_load_store_unit_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 64;

  // MIPS memory opcodes
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWU = 6'b100111;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Byte-enable constants (bit k enables lane [8k+7:8k])
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: is_load = 1'b1;
      default:                                      is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the load/store unit.
// Store side (driven from the incoming instruction):
//   st_opcode, st_offset, st_data  -> st_wdata (replicated), st_be, st_misalign
// Load side (driven from the registered in-flight access):
//   ld_opcode, ld_offset, ld_rdata -> ld_data (right-aligned, not extended)
// Little-endian: byte at offset k lives on lane [8k+7:8k].
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_load_store_unit_pkg::*;
(
  input  logic [5:0]  st_opcode,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic        st_misalign,
  input  logic [5:0]  ld_opcode,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  // Store data replication and byte enables; loads read the full word.
  always_comb begin
    st_wdata = st_data;
    st_be    = BE_NONE;
    case (st_opcode)
      OP_SB: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = BE_BYTE << st_offset;
      end
      OP_SH: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = st_offset[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      OP_SW: begin
        st_wdata = st_data;
        st_be    = BE_WORD;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        st_wdata = st_data;
        st_be    = BE_WORD;
      end
      default: begin
        st_wdata = st_data;
        st_be    = BE_NONE;
      end
    endcase
  end

  // Natural-alignment check: halfwords on even, words on 4-byte boundaries.
  always_comb begin
    st_misalign = 1'b0;
    case (st_opcode)
      OP_LH, OP_LHU, OP_SH: st_misalign = st_offset[0];
      OP_LW, OP_LWU, OP_SW: st_misalign = |st_offset;
      default:              st_misalign = 1'b0;
    endcase
  end

  // Right-align the addressed sub-word; upper bits are left as shifted.
  always_comb begin
    ld_data = ld_rdata;
    case (ld_opcode)
      OP_LB, OP_LBU: ld_data = ld_rdata >> {ld_offset, 3'b000};
      OP_LH, OP_LHU: ld_data = ld_rdata >> {ld_offset[1], 4'b0000};
      default:       ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_store_unit.sv
// -----------------------------------------------------------------------------
// mem_load_store_unit
// Memory-stage load/store unit with a two-state FSM (IDLE / ACCESS).
// Ports:
//   clk, reset             - clock, async active-high reset
//   i_valid/i_opcode/i_addr/i_wdata - memory-stage instruction
//   o_stall                - freeze upstream pipeline
//   o_mem_req/we/be/addr/wdata, i_mem_ack, i_mem_rdata - data-memory bus
//   o_wb_valid/o_wb_opcode/o_wb_rdata - load result to writeback
//   o_misalign, o_bus_err  - one-cycle exception pulses
// A request held for MEM_TIMEOUT ACCESS cycles without ack is aborted with
// o_bus_err; an ack in that final cycle still completes normally.
// -----------------------------------------------------------------------------
module mem_load_store_unit
  import mem_load_store_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [5:0]  i_opcode,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [5:0]  o_wb_opcode,
  output logic [31:0] o_wb_rdata,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_r;
  logic             we_r;
  logic [3:0]       be_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [5:0]       op_r;
  logic [1:0]       offset_r;
  logic             wb_valid_r;
  logic [5:0]       wb_op_r;
  logic [31:0]      wb_rdata_r;
  logic             misalign_r;
  logic             bus_err_r;

  logic [31:0] st_wdata_s;
  logic [3:0]  st_be_s;
  logic        misalign_s;
  logic [31:0] ld_data_s;
  logic        req_valid_s;
  logic        accept_s;
  logic        misalign_evt_s;
  logic        ack_s;
  logic        timeout_s;
  logic        stall_s;

  mem_lane_align u_lane (
    .st_opcode   (i_opcode),
    .st_offset   (i_addr[1:0]),
    .st_data     (i_wdata),
    .st_wdata    (st_wdata_s),
    .st_be       (st_be_s),
    .st_misalign (misalign_s),
    .ld_opcode   (op_r),
    .ld_offset   (offset_r),
    .ld_rdata    (i_mem_rdata),
    .ld_data     (ld_data_s)
  );

  // Request qualification and completion/timeout detection.
  always_comb begin
    req_valid_s    = (state_r == ST_IDLE) & i_valid &
                     (is_load(i_opcode) | is_store(i_opcode));
    accept_s       = req_valid_s & ~misalign_s;
    misalign_evt_s = req_valid_s & misalign_s;
    ack_s          = (state_r == ST_ACCESS) & i_mem_ack;
    timeout_s      = (state_r == ST_ACCESS) & ~i_mem_ack & (cnt_r == CNT_LAST);
  end

  // Stall: accept cycle in IDLE, and every ACCESS cycle without ack.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE:   stall_s = accept_s;
      ST_ACCESS: stall_s = ~i_mem_ack;
      default:   stall_s = 1'b0;
    endcase
  end

  // Stall is combinational by nature; reset forces it low independent of clk.
  assign o_stall = stall_s & ~reset;

  // FSM, access cycle counter and request strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      req_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (accept_s) begin
            state_r <= ST_ACCESS;
            req_r   <= 1'b1;
          end else begin
            req_r   <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (ack_s || timeout_s) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Capture the accepted access; held stable for the whole ACCESS phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r     <= 1'b0;
      be_r     <= BE_NONE;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      op_r     <= 6'b000000;
      offset_r <= 2'b00;
    end else if (accept_s) begin
      we_r     <= is_store(i_opcode);
      be_r     <= st_be_s;
      addr_r   <= {i_addr[31:2], 2'b00};
      wdata_r  <= st_wdata_s;
      op_r     <= i_opcode;
      offset_r <= i_addr[1:0];
    end
  end

  // Load writeback: pulse valid for one cycle, hold data and opcode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_r <= 1'b0;
      wb_op_r    <= 6'b000000;
      wb_rdata_r <= 32'h0000_0000;
    end else begin
      wb_valid_r <= ack_s & is_load(op_r);
      if (ack_s && is_load(op_r)) begin
        wb_op_r    <= op_r;
        wb_rdata_r <= ld_data_s;
      end
    end
  end

  // One-cycle exception pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_r <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      misalign_r <= misalign_evt_s;
      bus_err_r  <= timeout_s;
    end
  end

  assign o_mem_req   = req_r;
  assign o_mem_we    = we_r;
  assign o_mem_be    = be_r;
  assign o_mem_addr  = addr_r;
  assign o_mem_wdata = wdata_r;
  assign o_wb_valid  = wb_valid_r;
  assign o_wb_opcode = wb_op_r;
  assign o_wb_rdata  = wb_rdata_r;
  assign o_misalign  = misalign_r;
  assign o_bus_err   = bus_err_r;

endmodule
